// File: rtl/render_cmd_slave_if.sv
// rtl/render_cmd_slave_if.sv - memory-mapped register bus between the host master and the renderer command slave
interface render_cmd_slave_if;
    logic [3:0]  slave_address;
    logic        slave_read;
    logic [31:0] slave_readdata;
    logic        slave_write;
    logic [31:0] slave_writedata;
    logic        slave_waitrequest;

    modport master (
        output slave_address,
        output slave_read,
        output slave_write,
        output slave_writedata,
        input  slave_readdata,
        input  slave_waitrequest
    );

    modport slave (
        input  slave_address,
        input  slave_read,
        input  slave_write,
        input  slave_writedata,
        output slave_readdata,
        output slave_waitrequest
    );
endinterface

// File: rtl/render_cmd_slave.sv
// rtl/render_cmd_slave.sv - register front end that queues {x, y, tex} plot commands for the draw engine
module render_cmd_slave #(
    parameter int CMD_DEPTH = 4,
    parameter int X_MAX     = 319,
    parameter int Y_MAX     = 239
) (
    input  logic                    clk,
    input  logic                    rst_n,
    render_cmd_slave_if.slave       bus,
    output logic                    cmd_valid,
    input  logic                    cmd_ready,
    output logic [8:0]              cmd_x,
    output logic [7:0]              cmd_y,
    output logic [6:0]              cmd_tex,
    input  logic                    engine_busy
);

    localparam int AW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(CMD_DEPTH);

    localparam logic [3:0] ADDR_STATUS  = 4'd0;
    localparam logic [3:0] ADDR_X       = 4'd1;
    localparam logic [3:0] ADDR_Y       = 4'd2;
    localparam logic [3:0] ADDR_TEX     = 4'd4;
    localparam logic [3:0] ADDR_PLOTCNT = 4'd5;
    localparam logic [3:0] ADDR_PLOT    = 4'd6;
    localparam logic [3:0] ADDR_FLUSH   = 4'd7;

    logic [8:0]    x_reg;
    logic [7:0]    y_reg;
    logic [6:0]    tex_reg;
    logic [15:0]   plot_cnt;

    logic [23:0]   fifo_mem [CMD_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          flush;
    logic          wr_accept;
    logic [8:0]    x_sat;
    logic [7:0]    y_sat;

    assign fifo_full  = (count == FULL_COUNT);
    assign fifo_empty = (count == '0);
    assign cmd_valid  = !fifo_empty;
    assign pop        = cmd_valid && cmd_ready;

    // A full FIFO only stalls a plot when the engine is not taking the head this
    // same cycle; a pop frees the slot the push lands in.
    assign bus.slave_waitrequest = bus.slave_write && (bus.slave_address == ADDR_PLOT)
                                   && fifo_full && !cmd_ready;

    assign wr_accept = bus.slave_write && !bus.slave_waitrequest;
    assign push      = wr_accept && (bus.slave_address == ADDR_PLOT);
    assign flush     = wr_accept && (bus.slave_address == ADDR_FLUSH);

    assign {cmd_x, cmd_y, cmd_tex} = fifo_mem[rd_ptr];

    // Clamp coordinates so the engine never sees an off-screen position.
    always_comb begin
        x_sat = (bus.slave_writedata > 32'(X_MAX)) ? 9'(X_MAX) : bus.slave_writedata[8:0];
        y_sat = (bus.slave_writedata > 32'(Y_MAX)) ? 8'(Y_MAX) : bus.slave_writedata[7:0];
    end

    // Coordinate and texture registers written by the host.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_reg   <= '0;
            y_reg   <= '0;
            tex_reg <= '0;
        end else if (wr_accept) begin
            case (bus.slave_address)
                ADDR_X:   x_reg   <= x_sat;
                ADDR_Y:   y_reg   <= y_sat;
                ADDR_TEX: tex_reg <= bus.slave_writedata[6:0];
                default: ;
            endcase
        end
    end

    // Circular command buffer; flush wins over push/pop bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < CMD_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {x_reg, y_reg, tex_reg};
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Commands handed to the engine; a pop coinciding with flush still counts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            plot_cnt <= '0;
        end else if (pop) begin
            plot_cnt <= plot_cnt + 16'd1;
        end
    end

    // Zero-wait read mux; idle bus reads as zero.
    always_comb begin
        bus.slave_readdata = '0;
        if (bus.slave_read) begin
            case (bus.slave_address)
                ADDR_STATUS:  bus.slave_readdata = {26'd0, fifo_full, 4'(count),
                                                    (!fifo_empty) || engine_busy};
                ADDR_X:       bus.slave_readdata = {23'd0, x_reg};
                ADDR_Y:       bus.slave_readdata = {24'd0, y_reg};
                ADDR_TEX:     bus.slave_readdata = {25'd0, tex_reg};
                ADDR_PLOTCNT: bus.slave_readdata = {16'd0, plot_cnt};
                default:      bus.slave_readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_render_cmd_slave.sv
// tb/tb_render_cmd_slave.sv - randomized and directed bench for render_cmd_slave against a queue model
module tb_render_cmd_slave;

    localparam int CMD_DEPTH = 4;
    localparam int X_MAX     = 319;
    localparam int Y_MAX     = 239;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [8:0]  cmd_x;
    logic [7:0]  cmd_y;
    logic [6:0]  cmd_tex;
    logic        engine_busy;

    int checks;
    int errors;

    render_cmd_slave_if bus ();

    render_cmd_slave #(
        .CMD_DEPTH (CMD_DEPTH),
        .X_MAX     (X_MAX),
        .Y_MAX     (Y_MAX)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_x       (cmd_x),
        .cmd_y       (cmd_y),
        .cmd_tex     (cmd_tex),
        .engine_busy (engine_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a plain queue of {x, y, tex} plus the register values.
    logic [23:0] q [$];
    logic [8:0]  mx;
    logic [7:0]  my;
    logic [6:0]  mt;
    logic [15:0] mcnt;
    logic        model_live;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic model_wait();
        return bus.slave_write && (bus.slave_address == 4'd6)
               && (q.size() == CMD_DEPTH) && !cmd_ready;
    endfunction

    function automatic logic [31:0] model_rd();
        logic [31:0] r;
        r = 32'd0;
        if (bus.slave_read) begin
            case (bus.slave_address)
                4'd0: r = {26'd0, q.size() == CMD_DEPTH, 4'(q.size()),
                           (q.size() != 0) || engine_busy};
                4'd1: r = 32'(mx);
                4'd2: r = 32'(my);
                4'd4: r = 32'(mt);
                4'd5: r = 32'(mcnt);
                default: r = 32'd0;
            endcase
        end
        return r;
    endfunction

    initial begin
        logic        w;
        logic [23:0] dropped;
        model_live = 1'b0;
        mx = '0; my = '0; mt = '0; mcnt = '0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                q.delete();
                mx = '0; my = '0; mt = '0; mcnt = '0;
                model_live = 1'b1;
            end else begin
                w = model_wait();
                if (q.size() != 0 && cmd_ready) begin
                    dropped = q.pop_front();
                    mcnt = mcnt + 16'd1;
                end
                if (bus.slave_write && !w) begin
                    case (bus.slave_address)
                        4'd1: mx = (bus.slave_writedata > X_MAX) ? 9'(X_MAX) : bus.slave_writedata[8:0];
                        4'd2: my = (bus.slave_writedata > Y_MAX) ? 8'(Y_MAX) : bus.slave_writedata[7:0];
                        4'd4: mt = bus.slave_writedata[6:0];
                        4'd6: q.push_back({mx, my, mt});
                        4'd7: q.delete();
                        default: ;
                    endcase
                end
            end
        end
    end

    // Every-cycle compare against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (model_live) begin
                check("waitrequest", 32'(bus.slave_waitrequest), 32'(model_wait()));
                check("cmd_valid", 32'(cmd_valid), 32'(q.size() != 0));
                if (q.size() != 0) begin
                    check("cmd_head", 32'({cmd_x, cmd_y, cmd_tex}), 32'(q[0]));
                end
                check("readdata", bus.slave_readdata, model_rd());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        int   n;
        logic stall;
        n = 0;
        bus.slave_write     = 1'b1;
        bus.slave_address   = a;
        bus.slave_writedata = d;
        do begin
            @(negedge clk);
            stall = bus.slave_waitrequest;
            step();
            n++;
        end while (stall && n < 64);
        if (stall) begin
            errors++;
            $display("FAIL write_timeout: addr %0d still stalled after %0d cycles", a, n);
        end
        bus.slave_write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        bus.slave_read    = 1'b1;
        bus.slave_address = a;
        @(negedge clk);
        d = bus.slave_readdata;
        step();
        bus.slave_read = 1'b0;
    endtask

    task automatic pop_one();
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
    endtask

    int addr_tbl [12] = '{6, 6, 6, 6, 1, 2, 4, 7, 3, 0, 5, 12};

    initial begin
        logic [31:0] d;
        logic        stall;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        cmd_ready = 1'b0;
        engine_busy = 1'b0;
        bus.slave_address = '0;
        bus.slave_read = 1'b0;
        bus.slave_write = 1'b0;
        bus.slave_writedata = '0;
        step();
        step();
        rst_n = 1'b1;

        // Reset state
        for (int a = 0; a < 8; a++) begin
            rd(4'(a), d);
            check($sformatf("reset_read_%0d", a), d, 32'd0);
        end
        check("reset_cmd_valid", 32'(cmd_valid), 32'd0);
        check("reset_wait", 32'(bus.slave_waitrequest), 32'd0);

        // Saturation and single plot
        wr(4'd1, 32'd400);
        wr(4'd2, 32'd119);
        wr(4'd4, 32'h05);
        rd(4'd1, d); check("x_sat", d, 32'd319);
        rd(4'd2, d); check("y_rd", d, 32'd119);
        rd(4'd4, d); check("tex_rd", d, 32'h05);
        wr(4'd6, 32'd0);
        check("plot_valid", 32'(cmd_valid), 32'd1);
        check("plot_x", 32'(cmd_x), 32'd319);
        check("plot_y", 32'(cmd_y), 32'd119);
        check("plot_tex", 32'(cmd_tex), 32'h05);
        pop_one();
        check("pop_valid", 32'(cmd_valid), 32'd0);
        rd(4'd5, d); check("plotcnt_1", d, 32'd1);

        // Fill, stall, pop-and-push in one cycle, drain
        for (int i = 0; i < 4; i++) begin
            wr(4'd1, 32'(10 * (i + 1)));
            wr(4'd6, 32'd0);
        end
        rd(4'd0, d); check("status_full", d, 32'h29);
        wr(4'd1, 32'd50);
        bus.slave_write   = 1'b1;
        bus.slave_address = 4'd6;
        @(negedge clk);
        check("wait_when_full", 32'(bus.slave_waitrequest), 32'd1);
        step();
        cmd_ready = 1'b1;
        @(negedge clk);
        check("wait_released_by_pop", 32'(bus.slave_waitrequest), 32'd0);
        step();
        bus.slave_write = 1'b0;
        cmd_ready = 1'b0;
        rd(4'd0, d); check("status_still_full", d, 32'h29);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drain_x_%0d", k), 32'(cmd_x), 32'(20 + 10 * k));
            pop_one();
        end
        check("drained_valid", 32'(cmd_valid), 32'd0);
        rd(4'd5, d); check("plotcnt_6", d, 32'd6);

        // Fill command held under back-pressure
        wr(4'd4, 32'h6A);
        wr(4'd6, 32'd0);
        for (int k = 0; k < 3; k++) begin
            check("hold_tex", 32'(cmd_tex), 32'h6A);
            check("hold_x", 32'(cmd_x), 32'd50);
            check("hold_valid", 32'(cmd_valid), 32'd1);
            step();
        end
        pop_one();

        // Flush
        for (int i = 0; i < 3; i++) wr(4'd6, 32'd0);
        engine_busy = 1'b1;
        wr(4'd7, 32'd0);
        check("flush_valid", 32'(cmd_valid), 32'd0);
        rd(4'd0, d); check("flush_status_busy", d, 32'd1);
        rd(4'd5, d); check("flush_plotcnt", d, 32'd7);
        engine_busy = 1'b0;
        rd(4'd0, d); check("flush_status_idle", d, 32'd0);

        // Reset mid-handshake
        wr(4'd6, 32'd0);
        wr(4'd6, 32'd0);
        cmd_ready = 1'b1;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        cmd_ready = 1'b0;
        check("rst_valid", 32'(cmd_valid), 32'd0);
        rd(4'd5, d); check("rst_plotcnt", d, 32'd0);
        rd(4'd1, d); check("rst_x", d, 32'd0);
        rd(4'd4, d); check("rst_tex", d, 32'd0);

        // Randomized traffic checked by the model every cycle
        stall = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (!stall) begin
                bus.slave_write = 1'b0;
                bus.slave_read  = 1'b0;
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4: begin
                        bus.slave_write     = 1'b1;
                        bus.slave_address   = 4'(addr_tbl[$urandom_range(0, 11)]);
                        bus.slave_writedata = ($urandom_range(0, 3) != 0) ? 32'($urandom_range(0, 600)) : $urandom;
                    end
                    5, 6, 7: begin
                        bus.slave_read    = 1'b1;
                        bus.slave_address = 4'($urandom_range(0, 15));
                    end
                    default: ;
                endcase
            end
            cmd_ready   = (c < 750) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            engine_busy = 1'($urandom_range(0, 1));
            rst_n       = ($urandom_range(0, 255) != 0);
            @(negedge clk);
            stall = bus.slave_waitrequest;
            step();
        end
        bus.slave_write = 1'b0;
        bus.slave_read  = 1'b0;
        cmd_ready = 1'b0;
        engine_busy = 1'b0;
        rst_n = 1'b1;

        // PLOTCNT wrap after 65536 accepted commands
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        cmd_ready = 1'b1;
        bus.slave_write   = 1'b1;
        bus.slave_address = 4'd6;
        repeat (65536) step();
        bus.slave_write = 1'b0;
        cmd_ready = 1'b0;
        rd(4'd5, d); check("plotcnt_ffff", d, 32'hFFFF);
        pop_one();
        rd(4'd5, d); check("plotcnt_wrap", d, 32'd0);
        check("wrap_valid", 32'(cmd_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
